// File: rtl/icache_refill_pkg.sv
// Shared types and default widths for the icache refill sequencer.
// Optional macro ICACHE_REFILL_PARITY_EN adds per-byte parity on data-array writes.
package icache_refill_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned BEATS_DEF  = 8;
  localparam int unsigned IDX_W_DEF  = 6;

  // Beat-counter width and byte-offset width of one cache line.
  localparam int unsigned BEAT_W_DEF = $clog2(BEATS_DEF);
  localparam int unsigned OFF_W_DEF  = $clog2(BEATS_DEF * DATA_W_DEF / 8);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACQ   = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int unsigned line_off_w(input int unsigned beats, input int unsigned data_w);
    return $clog2(beats * data_w / 8);
  endfunction

endpackage

// File: rtl/icache_refill_seq_if.sv
// Fetch-miss, memory-port and data-array signals of the refill sequencer.
// wr_par exists only when ICACHE_REFILL_PARITY_EN is defined.
interface icache_refill_seq_if
  import icache_refill_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BEATS  = BEATS_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
);

  localparam int unsigned BEAT_W = $clog2(BEATS);

  logic              miss_valid;
  logic              miss_ready;
  logic [ADDR_W-1:0] miss_addr;
  logic              kill;

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;

  logic              d_valid;
  logic [DATA_W-1:0] d_data;
  logic              d_error;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [BEAT_W-1:0] wr_beat;
  logic [DATA_W-1:0] wr_data;
`ifdef ICACHE_REFILL_PARITY_EN
  logic [DATA_W/8-1:0] wr_par;
`endif

  logic              tag_wr;
  logic              fill_active;
  logic              fill_ack;
  logic              fill_err;
  logic              kill_seen;
  logic              clk_gate_en;

  // Sequencer side.
  modport master (
    input  miss_valid, miss_addr, kill, a_ready, d_valid, d_data, d_error,
    output miss_ready, a_valid, a_addr, wr_en, wr_idx, wr_beat, wr_data,
           tag_wr, fill_active, fill_ack, fill_err, kill_seen, clk_gate_en
`ifdef ICACHE_REFILL_PARITY_EN
         , wr_par
`endif
  );

  // Fetch stage / memory / data-array side.
  modport slave (
    output miss_valid, miss_addr, kill, a_ready, d_valid, d_data, d_error,
    input  miss_ready, a_valid, a_addr, wr_en, wr_idx, wr_beat, wr_data,
           tag_wr, fill_active, fill_ack, fill_err, kill_seen, clk_gate_en
`ifdef ICACHE_REFILL_PARITY_EN
         , wr_par
`endif
  );

endinterface

// File: rtl/icache_refill_beat_ctr.sv
// Beat counter for one line: increments per consumed beat, flags the last beat, wraps to 0.
module icache_refill_beat_ctr
  import icache_refill_pkg::*;
#(
  parameter int unsigned BEATS = BEATS_DEF,
  parameter int unsigned CW    = $clog2(BEATS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last;

  assign last = (cnt_q == CW'(BEATS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = last;

endmodule

// File: rtl/icache_refill_seq.sv
// Instruction-cache miss refill sequencer: one line-fill read per miss, beats written to the data array.
// Define ICACHE_REFILL_PARITY_EN to generate per-byte even parity (wr_par) alongside wr_data.
module icache_refill_seq
  import icache_refill_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BEATS  = BEATS_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input logic                clock,
  input logic                reset,
  icache_refill_seq_if.master bus
);

  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned OFF_W  = line_off_w(BEATS, DATA_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'(1) << OFF_W) - 64'(1));

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic              err_q;
  logic              err_d;
  logic              kill_q;
  logic              kill_d;

  logic              wr_en;
  logic              cnt_inc;
  logic              cnt_clr;
  logic [BEAT_W-1:0] cnt;
  logic              cnt_last;
  logic              done;

  icache_refill_beat_ctr #(
    .BEATS (BEATS),
    .CW    (BEAT_W)
  ) u_beat_ctr (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  assign cnt_clr = (state_q == ST_IDLE);

  // Next-state, sticky-flag and write-strobe logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    err_d   = err_q;
    kill_d  = kill_q;
    wr_en   = 1'b0;
    cnt_inc = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.miss_valid) begin
          addr_d  = bus.miss_addr & ~OFF_MASK;
          idx_d   = IDX_W'(bus.miss_addr >> OFF_W);
          state_d = ST_ACQ;
        end
      end

      ST_ACQ: begin
        // A kill here cannot retract the request; the line is drained instead.
        if (bus.kill) begin
          kill_d = 1'b1;
        end
        if (bus.a_ready) begin
          state_d = (bus.kill || kill_q) ? ST_DRAIN : ST_FILL;
        end
      end

      ST_FILL: begin
        if (bus.kill) begin
          kill_d  = 1'b1;
          cnt_inc = bus.d_valid;
          state_d = (bus.d_valid && cnt_last) ? ST_DONE : ST_DRAIN;
        end else if (bus.d_valid) begin
          wr_en   = 1'b1;
          cnt_inc = 1'b1;
          if (bus.d_error) begin
            err_d = 1'b1;
          end
          if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DRAIN: begin
        if (bus.kill) begin
          kill_d = 1'b1;
        end
        if (bus.d_valid) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        err_d   = 1'b0;
        kill_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      kill_q  <= kill_d;
    end
  end

  assign done = (state_q == ST_DONE);

  assign bus.miss_ready  = (state_q == ST_IDLE);
  assign bus.fill_active = (state_q != ST_IDLE);
  assign bus.a_valid     = (state_q == ST_ACQ);
  assign bus.a_addr      = addr_q;

  assign bus.wr_en   = wr_en;
  assign bus.wr_idx  = idx_q;
  assign bus.wr_beat = cnt;
  assign bus.wr_data = bus.d_data;

  assign bus.fill_ack  = done;
  assign bus.fill_err  = done & err_q;
  assign bus.kill_seen = done & kill_q;
  assign bus.tag_wr    = done & ~err_q & ~kill_q;

  // Combinational so the clock is already running in the cycle a miss arrives.
  assign bus.clk_gate_en = bus.fill_active | bus.miss_valid;

`ifdef ICACHE_REFILL_PARITY_EN
  logic [DATA_W/8-1:0] par_c;

  // Errored beats get inverted parity so a later fetch of that line traps.
  always_comb begin
    par_c = '0;
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      par_c[b] = (^bus.d_data[8*b +: 8]) ^ bus.d_error;
    end
  end

  assign bus.wr_par = par_c;
`endif

endmodule

// File: tb/tb_icache_refill_seq.sv
// Self-checking bench for icache_refill_seq: vector table for a clean fill, scoreboard for writes/acks.
module tb_icache_refill_seq;
  import icache_refill_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BEATS  = 8;
  localparam int unsigned IDX_W  = 6;
  localparam logic [31:0] CLEAN_ADDR = 32'h8000_0040;

  typedef struct {
    logic [2:0]  beat;
    logic [5:0]  idx;
    logic [63:0] data;
    logic        err;
  } wr_exp_t;

  typedef struct {
    logic err;
    logic kill;
    logic tag;
  } ack_exp_t;

  typedef struct {
    logic       mv, ar, dv, kl;
    logic       mr, av, we;
    logic [2:0] beat;
    logic       fa, ack, tag, cge;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic mon_en = 1'b0;
  logic prev_ack = 1'b0;
  int   errors = 0;
  int   checks = 0;

  wr_exp_t     exp_wr[$];
  ack_exp_t    exp_ack[$];
  logic [31:0] exp_aq[$];

  always #5 clock = ~clock;

  icache_refill_seq_if #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .BEATS (BEATS), .IDX_W (IDX_W)
  ) ifc ();

  icache_refill_seq #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .BEATS (BEATS), .IDX_W (IDX_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFC0;
  endfunction

  function automatic logic [5:0] idx_of(input logic [31:0] a);
    return a[11:6];
  endfunction

`ifdef ICACHE_REFILL_PARITY_EN
  function automatic logic [7:0] exp_par(input logic [63:0] d, input logic e);
    logic [7:0] p;
    for (int b = 0; b < 8; b++) p[b] = (^d[8*b +: 8]) ^ e;
    return p;
  endfunction
`endif

  function automatic vec_t mk(input logic mv, input logic ar, input logic dv, input logic kl,
                              input logic mr, input logic av, input logic we, input int beat,
                              input logic fa, input logic ack, input logic tag, input logic cge);
    vec_t v;
    v.mv = mv; v.ar = ar; v.dv = dv; v.kl = kl;
    v.mr = mr; v.av = av; v.we = we; v.beat = 3'(beat);
    v.fa = fa; v.ack = ack; v.tag = tag; v.cge = cge;
    return v;
  endfunction

  task automatic push_wr(input int beat, input logic [5:0] idx, input logic [63:0] data, input logic err);
    wr_exp_t e;
    e.beat = 3'(beat); e.idx = idx; e.data = data; e.err = err;
    exp_wr.push_back(e);
  endtask

  task automatic push_ack(input logic err, input logic kill, input logic tag);
    ack_exp_t a;
    a.err = err; a.kill = kill; a.tag = tag;
    exp_ack.push_back(a);
  endtask

  task automatic drive(input logic mv, input logic [31:0] ma, input logic ar, input logic dv,
                       input logic de, input logic kl, input logic [63:0] dd);
    @(posedge clock);
    #1;
    ifc.miss_valid = mv;
    ifc.miss_addr  = ma;
    ifc.a_ready    = ar;
    ifc.d_valid    = dv;
    ifc.d_error    = de;
    ifc.kill       = kl;
    ifc.d_data     = dd;
  endtask

  // Scoreboard and invariant monitor, sampled mid-cycle.
  always @(negedge clock) begin
    wr_exp_t  e;
    ack_exp_t a;
    if (mon_en) begin
      if (ifc.wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: wr_en=1 beat=%0d, expected no write", ifc.wr_beat);
        end else begin
          e = exp_wr.pop_front();
          chk("sb_wr_beat", 64'(ifc.wr_beat), 64'(e.beat));
          chk("sb_wr_idx",  64'(ifc.wr_idx),  64'(e.idx));
          chk("sb_wr_data", ifc.wr_data, e.data);
`ifdef ICACHE_REFILL_PARITY_EN
          chk("sb_wr_par", 64'(ifc.wr_par), 64'(exp_par(e.data, e.err)));
`endif
        end
      end
      if (ifc.fill_ack) begin
        if (exp_ack.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: fill_ack=1, expected none");
        end else begin
          a = exp_ack.pop_front();
          chk("sb_fill_err",  64'(ifc.fill_err),  64'(a.err));
          chk("sb_kill_seen", 64'(ifc.kill_seen), 64'(a.kill));
          chk("sb_tag_wr",    64'(ifc.tag_wr),    64'(a.tag));
        end
      end
      if (ifc.a_valid) begin
        if (exp_aq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_valid_unexpected: a_addr=%0h", ifc.a_addr);
        end else begin
          chk("sb_a_addr", 64'(ifc.a_addr), 64'(exp_aq[0]));
          if (ifc.a_ready) void'(exp_aq.pop_front());
        end
      end
      chk("inv_wr_active",    64'(ifc.wr_en & ~ifc.fill_active), 64'(0));
      chk("inv_tag_ack",      64'(ifc.tag_wr & ~ifc.fill_ack),   64'(0));
      chk("inv_ack_b2b",      64'(ifc.fill_ack & prev_ack),      64'(0));
      chk("inv_ready_active", 64'(ifc.miss_ready & ifc.fill_active), 64'(0));
      prev_ack = ifc.fill_ack;
    end
  end

  // One full miss: accept, optional a_ready stall, BEATS response beats, DONE.
  task automatic do_fill(input logic [31:0] addr, input int stall, input int err_beat,
                         input int kill_beat, input logic hold_mv, input logic [31:0] next_addr);
    logic [63:0] dd;
    logic        wr;
    drive(1'b1, addr, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    exp_aq.push_back(align(addr));
    @(negedge clock);
    chk("acc_miss_ready", 64'(ifc.miss_ready), 64'(1));
    chk("acc_clk_gate",   64'(ifc.clk_gate_en), 64'(1));
    for (int s = 0; s < stall; s++) begin
      drive(hold_mv, next_addr, 1'b0, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_0BAD_F00D);
      @(negedge clock);
      chk("stall_a_valid", 64'(ifc.a_valid), 64'(1));
      chk("stall_active",  64'(ifc.fill_active), 64'(1));
      chk("stall_no_wr",   64'(ifc.wr_en), 64'(0));
    end
    drive(hold_mv, next_addr, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clock);
    chk("hs_a_valid", 64'(ifc.a_valid), 64'(1));
    for (int b = 0; b < int'(BEATS); b++) begin
      dd = {$urandom(), $urandom()};
      wr = (b < kill_beat);
      drive(hold_mv, next_addr, 1'b0, 1'b1, (b == err_beat), (b == kill_beat), dd);
      if (wr) push_wr(b, idx_of(addr), dd, (b == err_beat));
      @(negedge clock);
      chk($sformatf("beat%0d_wr_en", b), 64'(ifc.wr_en), 64'(wr));
      chk($sformatf("beat%0d_active", b), 64'(ifc.fill_active), 64'(1));
      chk($sformatf("beat%0d_no_ack", b), 64'(ifc.fill_ack), 64'(0));
    end
    push_ack((err_beat < int'(BEATS)) && (err_beat < kill_beat), (kill_beat < int'(BEATS)),
             (err_beat >= int'(BEATS)) && (kill_beat >= int'(BEATS)));
    drive(hold_mv, next_addr, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clock);
    chk("done_ack",        64'(ifc.fill_ack), 64'(1));
    chk("done_miss_ready", 64'(ifc.miss_ready), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[12];
    vec_t        v;
    logic [63:0] dd;
    logic [31:0] ra;

    reset = 1'b1;
    ifc.miss_valid = 1'b0; ifc.miss_addr = '0; ifc.kill = 1'b0;
    ifc.a_ready = 1'b0; ifc.d_valid = 1'b0; ifc.d_data = '0; ifc.d_error = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_miss_ready",  64'(ifc.miss_ready),  64'(1));
    chk("rst_a_valid",     64'(ifc.a_valid),     64'(0));
    chk("rst_wr_en",       64'(ifc.wr_en),       64'(0));
    chk("rst_tag_wr",      64'(ifc.tag_wr),      64'(0));
    chk("rst_fill_ack",    64'(ifc.fill_ack),    64'(0));
    chk("rst_fill_err",    64'(ifc.fill_err),    64'(0));
    chk("rst_kill_seen",   64'(ifc.kill_seen),   64'(0));
    chk("rst_fill_active", 64'(ifc.fill_active), 64'(0));
    chk("rst_clk_gate",    64'(ifc.clk_gate_en), 64'(0));
    mon_en = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Clean fill at 0x8000_0040 with a_ready/d_valid held high: DONE lands on row 10.
    tbl[0]  = mk(1, 1, 1, 0,  1, 0, 0, 0,  0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 1, 0,  0, 1, 0, 0,  1, 0, 0, 1);
    for (int k = 0; k < 8; k++) tbl[2+k] = mk(0, 1, 1, 0,  0, 0, 1, k,  1, 0, 0, 1);
    tbl[10] = mk(0, 1, 1, 0,  0, 0, 0, 0,  1, 1, 1, 1);
    tbl[11] = mk(0, 1, 1, 0,  1, 0, 0, 0,  0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      v  = tbl[i];
      dd = {$urandom(), $urandom()};
      drive(v.mv, CLEAN_ADDR, v.ar, v.dv, 1'b0, v.kl, dd);
      if (v.mv && v.mr) exp_aq.push_back(32'h8000_0040);
      if (v.we) push_wr(int'(v.beat), 6'd1, dd, 1'b0);
      if (v.ack) push_ack(1'b0, 1'b0, v.tag);
      @(negedge clock);
      chk($sformatf("t%0d_miss_ready", i),  64'(ifc.miss_ready),  64'(v.mr));
      chk($sformatf("t%0d_a_valid", i),     64'(ifc.a_valid),     64'(v.av));
      chk($sformatf("t%0d_wr_en", i),       64'(ifc.wr_en),       64'(v.we));
      chk($sformatf("t%0d_fill_active", i), 64'(ifc.fill_active), 64'(v.fa));
      chk($sformatf("t%0d_fill_ack", i),    64'(ifc.fill_ack),    64'(v.ack));
      chk($sformatf("t%0d_tag_wr", i),      64'(ifc.tag_wr),      64'(v.tag));
      chk($sformatf("t%0d_clk_gate", i),    64'(ifc.clk_gate_en), 64'(v.cge));
      if (v.we) chk($sformatf("t%0d_wr_beat", i), 64'(ifc.wr_beat), 64'(v.beat));
    end

    // a_ready low for 5 cycles, unaligned miss address.
    do_fill(32'h1234_569F, 5, BEATS, BEATS, 1'b0, 32'h0);
    // Bus error on beat 3.
    do_fill(32'h0000_0A40, 0, 3, BEATS, 1'b0, 32'h0);
    // Kill during beat 4, then a new miss right after DONE.
    do_fill(32'hCAFE_0FC0, 0, BEATS, 4, 1'b0, 32'h0);
    do_fill(32'h0000_1000, 0, BEATS, BEATS, 1'b0, 32'h0);

    // Synchronous reset asserted during beat 2.
    ra = 32'h4000_0280;
    drive(1'b1, ra, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    exp_aq.push_back(align(ra));
    @(negedge clock);
    chk("rs_accept", 64'(ifc.miss_ready), 64'(1));
    drive(1'b0, ra, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clock);
    for (int b = 0; b < 3; b++) begin
      dd = {$urandom(), $urandom()};
      drive(1'b0, ra, 1'b0, 1'b1, 1'b0, 1'b0, dd);
      if (b == 2) reset = 1'b1;
      push_wr(b, idx_of(ra), dd, 1'b0);
      @(negedge clock);
      chk($sformatf("rs_beat%0d_wr_en", b), 64'(ifc.wr_en), 64'(1));
    end
    drive(1'b0, ra, 1'b0, 1'b1, 1'b0, 1'b0, 64'h1234);
    reset = 1'b0;
    @(negedge clock);
    chk("rs_miss_ready",  64'(ifc.miss_ready),  64'(1));
    chk("rs_fill_active", 64'(ifc.fill_active), 64'(0));
    chk("rs_wr_en",       64'(ifc.wr_en),       64'(0));
    chk("rs_a_valid",     64'(ifc.a_valid),     64'(0));
    chk("rs_fill_ack",    64'(ifc.fill_ack),    64'(0));
    chk("rs_tag_wr",      64'(ifc.tag_wr),      64'(0));
    chk("rs_clk_gate",    64'(ifc.clk_gate_en), 64'(0));

    // Back-to-back misses with miss_valid held high through the first fill.
    do_fill(32'h0000_2040, 0, BEATS, BEATS, 1'b1, 32'h0000_3080);
    do_fill(32'h0000_3080, 0, BEATS, BEATS, 1'b0, 32'h0);

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clock);
    chk("end_idle_ready", 64'(ifc.miss_ready),  64'(1));
    chk("end_clk_gate",   64'(ifc.clk_gate_en), 64'(0));
    chk("end_wr_pending",   64'(exp_wr.size()),  64'(0));
    chk("end_ack_pending",  64'(exp_ack.size()), 64'(0));
    chk("end_addr_pending", 64'(exp_aq.size()),  64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_refill_seq.md
Name: icache_refill_seq

Overview:
- Instruction-cache miss refill sequencer.
- Accepts one miss request at a time from the fetch stage. Issues a single line-fill read to the memory port, then writes the returned beats into the data array.
- Produces the refill status flags (fill_active, fill_ack, fill_err, kill_seen, tag_wr) and the clock-gate enable that the icache assertion monitor downstream samples. It is the stage directly feeding that monitor.

Parameters:
- ADDR_W, 32, physical address width.
- DATA_W, 64, beat width in bits.
- BEATS, 8, beats per cache line; power of two, 2 or greater.
- IDX_W, 6, cache set index width.

Ports:
- clock  in  1  block clock; all state sampled on rising edge.
- reset  in  1  synchronous, active-high reset.
- miss_valid  in  1  miss request valid.
- miss_ready  out  1  sequencer can accept a miss.
- miss_addr  in  ADDR_W  line address of the miss; low log2(BEATS*DATA_W/8) bits ignored.
- kill  in  1  invalidate/flush: abandon the current fill.
- a_valid  out  1  memory read request valid.
- a_ready  in  1  memory accepts request.
- a_addr  out  ADDR_W  line-aligned request address.
- d_valid  in  1  response beat valid; always accepted, no backpressure.
- d_data  in  DATA_W  response beat data.
- d_error  in  1  response beat carries bus error.
- wr_en  out  1  data-array write strobe.
- wr_idx  out  IDX_W  set index being filled.
- wr_beat  out  log2(BEATS)  beat number within line.
- wr_data  out  DATA_W  data to write.
- tag_wr  out  1  one-cycle pulse: install tag (fill completed cleanly).
- fill_active  out  1  high in any state other than IDLE.
- fill_ack  out  1  one-cycle pulse at end of a fill (clean, errored or killed).
- fill_err  out  1  qualifies fill_ack: a beat of this fill had d_error.
- kill_seen  out  1  qualifies fill_ack: the fill was killed.
- clk_gate_en  out  1  icache clock-gate enable.

Behaviour:
- States: IDLE, ACQ, FILL, DRAIN, DONE.
- Reset: state=IDLE; beat counter=0; sticky error=0; sticky kill=0.
- Reset outputs: miss_ready=1, a_valid=0, wr_en=0, tag_wr=0, fill_ack=0, fill_err=0, kill_seen=0, fill_active=0, clk_gate_en=0.
- Reset mid-fill returns to IDLE next cycle. Later beats of the abandoned fill are not filtered; the system is reset together with memory.
- IDLE:
  - miss_ready=1.
  - On miss_valid: latch line-aligned address and index (address bits above the line offset, low IDX_W of them), then go to ACQ.
  - kill in IDLE is ignored.
- ACQ:
  - a_valid=1 and a_addr is stable until a_ready.
  - On a_valid&a_ready, go to FILL, or to DRAIN if kill is also high that cycle.
  - kill before handshake: still complete the request (no retraction) and go to DRAIN.
- FILL:
  - Each d_valid beat: wr_en=1 combinationally in the same cycle; wr_beat=counter; wr_data=d_data; counter increments.
  - If d_error: wr_en for that beat is still asserted; sticky error is set.
  - kill: sticky kill is set. The kill-cycle beat itself is not written (wr_en=0) and the state moves to DRAIN.
  - After the last beat (counter==BEATS-1 with d_valid), go to DONE and wrap the counter to 0.
- DRAIN: count and consume beats without writing. After the last beat, go to DONE.
- DONE, single cycle:
  - fill_ack=1.
  - fill_err=sticky error.
  - kill_seen=sticky kill.
  - tag_wr=1 only if neither sticky flag is set.
  - Clear sticky flags and return to IDLE. miss_ready=0 in DONE, so the minimum gap between fills is 1 cycle.
- Mutual exclusion invariants (checked downstream):
  - wr_en implies fill_active.
  - tag_wr implies fill_ack.
  - fill_ack never in two consecutive cycles.
  - a_valid only in ACQ.
  - miss_ready and fill_active never both high.
- d_valid outside FILL/DRAIN is a protocol error: the beat is ignored, with no state change.
- clk_gate_en = fill_active | miss_valid. It is combinational so the first cycle of a miss is clocked.
- Latency, with a_ready and d_valid always high: request accepted cycle 0; ACQ cycle 1; beats cycles 2..BEATS+1; DONE cycle BEATS+2.

Optional Feature:
- ICACHE_REFILL_PARITY_EN
  - Defined: adds output wr_par [DATA_W/8], the even parity per byte of wr_data, valid with wr_en. A d_error beat inverts all parity bits so later fetches trap.
  - Undefined: port absent, no parity logic.

Decomposition:
- Package icache_refill_pkg: state enum (IDLE, ACQ, FILL, DRAIN, DONE); localparam for beat-counter width (log2 BEATS); line-offset width.
- Sub-module icache_refill_beat_ctr: beat counter with increment, terminal-count (last) flag and wrap. Used by both FILL and DRAIN.
- Parity generator stays inline under the macro.

Test Plan:
- Clean fill, BEATS=8, miss_addr=0x8000_0040, a_ready/d_valid always high:
  - a_addr=0x8000_0040.
  - wr_beat 0..7 on consecutive cycles; wr_idx=1.
  - tag_wr and fill_ack both at cycle 10; fill_err=0.
- a_ready held low 5 cycles: a_valid stays 1 with a_addr stable; fill_active=1 throughout; no wr_en before handshake.
- d_error on beat 3: all 8 wr_en issued; fill_ack with fill_err=1; tag_wr=0.
- kill during beat 4: beats 0-3 written, beats 4-7 with wr_en=0; fill_ack with kill_seen=1; tag_wr=0; next miss accepted 1 cycle later.
- reset asserted during beat 2: next cycle state IDLE with miss_ready=1, all pulses 0, clk_gate_en follows miss_valid only.
- Back-to-back misses with miss_valid held high: second accepted the cycle after DONE; fill_ack pulses separated by at least 1 cycle.
